// File: rtl/bus_arbiter_rr.sv
// Round-robin system-bus arbiter with turnaround cycle, burst limit and watchdog.
// Latency: grant registered one cycle after req is sampled; one dead cycle between owners.
// Backpressure: grant is held while BUS_req is high; release and preempt wait for BUS_req low.
module bus_arbiter_rr #(
    parameter int NREQ       = 8,
    parameter int MAX_BURST  = 16,
    parameter int TIMEOUT    = 255,
    parameter bit HI_PRIO_EN = 1'b1
) (
    input  logic            clk,
    input  logic            clr_in,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    input  logic            BUS_req,
    input  logic            BUS_ready,
    output logic            bus_timeout,
    output logic [2:0]      owner,
    output logic            busy
);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [WW-1:0]   WAIT_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);
    localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        HANDOVER = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [2:0]      owner_q, owner_d;
    logic [2:0]      last_q, last_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            timeout_q, timeout_d;

    logic            win_vld;
    logic [2:0]      win_idx;
    int              best_dist;
    logic            owner_req;
    logic            other_req;
    logic            stall;
    logic            done;

    // Winner is the set request closest after last_q in circular order.
    always_comb begin
        win_vld   = 1'b0;
        win_idx   = '0;
        best_dist = NREQ;
        if (HI_PRIO_EN && req[0]) begin
            win_vld = 1'b1;
            win_idx = '0;
        end else begin
            for (int j = 0; j < NREQ; j++) begin
                if (req[j] && (((j + 2*NREQ - 1 - int'(last_q)) % NREQ) < best_dist)) begin
                    best_dist = (j + 2*NREQ - 1 - int'(last_q)) % NREQ;
                    win_idx   = 3'(j);
                    win_vld   = 1'b1;
                end
            end
        end
    end

    assign owner_req = |(req & grant_q);
    assign other_req = |(req & ~grant_q);
    assign stall     = BUS_req && !BUS_ready;
    assign done      = BUS_req && BUS_ready;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        last_d    = last_q;
        burst_d   = burst_q;
        wait_d    = wait_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE, HANDOVER: begin
                state_d = IDLE;
                grant_d = '0;
                if (win_vld) begin
                    state_d = GRANT;
                    grant_d = ONE_HOT0 << win_idx;
                    owner_d = win_idx;
                    last_d  = win_idx;
                    burst_d = '0;
                    wait_d  = '0;
                end
            end
            GRANT: begin
                if (done && (burst_q != BURST_MAX)) begin
                    burst_d = burst_q + BW'(1);
                end
                wait_d = (stall && (TIMEOUT != 0)) ? wait_q + WW'(1) : '0;
                if ((TIMEOUT != 0) && stall && (wait_q == WAIT_LAST)) begin
                    timeout_d = 1'b1;
                    wait_d    = '0;
                    grant_d   = '0;
                    state_d   = HANDOVER;
                end else if (!BUS_req && (!owner_req || ((burst_q == BURST_MAX) && other_req))) begin
                    grant_d = '0;
                    state_d = HANDOVER;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_in) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            last_q    <= 3'(NREQ - 1);
            burst_q   <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            burst_q   <= burst_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign owner       = owner_q;
    assign busy        = (state_q == GRANT);
    assign bus_timeout = timeout_q;

endmodule
